flexbex_data_bus_bridge: RTL and testbench

Data-side bus bridge directly downstream of the core load/store unit. It accepts the LSU's req/gnt/rvalid transactions (byte address, byte enables, write data) and routes each one to a single-port synchronous SRAM or a peripheral ready/ack port; unmapped addresses get an error response. One transaction is outstanding at a time, and a new request can be granted in the same cycle as the previous response, so misaligned split accesses run back-to-back.

---
 rtl/flexbex_bus_pkg.sv | 35 +++
 rtl/flexbex_bus_addr_decode.sv | 33 +++
 rtl/flexbex_data_bus_bridge.sv | 139 +++++++++++++
 tb/tb_flexbex_data_bus_bridge.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flexbex_bus_pkg.sv
// Shared types and default address map for the data-side bus bridge.
package flexbex_bus_pkg;

    // Bridge FSM states.
    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StSramResp   = 3'd1,
        StPeriphWait = 3'd2,
        StPeriphResp = 3'd3,
        StErrResp    = 3'd4
    } bridge_state_e;

    // Target region of a decoded byte address.
    typedef enum logic [1:0] {
        REGION_SRAM   = 2'd0,
        REGION_PERIPH = 2'd1,
        REGION_ERR    = 2'd2
    } region_e;

    // Default address map.
    localparam int unsigned DefaultSramAw     = 12;
    localparam logic [31:0] DefaultSramBase   = 32'h0000_0000;
    localparam int unsigned DefaultPeriphAw   = 16;
    localparam logic [31:0] DefaultPeriphBase = 32'h1000_0000;
    localparam int unsigned DefaultTimeout    = 255;

    // Width of the peripheral wait counter.
    localparam int unsigned TimeoutCntW = 10;

    // States that present a response to the LSU.
    function automatic logic is_resp_state(bridge_state_e s);
        return (s == StSramResp) || (s == StPeriphResp) || (s == StErrResp);
    endfunction

endpackage

// File: rtl/flexbex_bus_addr_decode.sv
// Combinational byte-address to region decode. SRAM wins if the windows overlap.
module flexbex_bus_addr_decode
    import flexbex_bus_pkg::*;
#(
    parameter int unsigned SRAM_AW     = DefaultSramAw,
    parameter logic [31:0] SRAM_BASE   = DefaultSramBase,
    parameter int unsigned PERIPH_AW   = DefaultPeriphAw,
    parameter logic [31:0] PERIPH_BASE = DefaultPeriphBase
) (
    input  logic [31:0] addr,
    output region_e     region
);

    // SRAM window is 4 * 2^SRAM_AW bytes, so compare above the word and index bits.
    localparam int unsigned SramShift = SRAM_AW + 2;

    logic sram_hit;
    logic periph_hit;

    assign sram_hit   = (addr >> SramShift) == (SRAM_BASE >> SramShift);
    assign periph_hit = (addr >> PERIPH_AW) == (PERIPH_BASE >> PERIPH_AW);

    // Priority select of the hit region.
    always_comb begin
        region = REGION_ERR;
        if (sram_hit) begin
            region = REGION_SRAM;
        end else if (periph_hit) begin
            region = REGION_PERIPH;
        end
    end

endmodule

// File: rtl/flexbex_data_bus_bridge.sv
// LSU data bus bridge: routes req/gnt/rvalid transactions to a synchronous SRAM,
// a ready/ack peripheral port, or an error responder. One transaction in flight;
// a new request may be granted in the same cycle as the previous response.
module flexbex_data_bus_bridge
    import flexbex_bus_pkg::*;
#(
    parameter int unsigned SRAM_AW     = DefaultSramAw,
    parameter logic [31:0] SRAM_BASE   = DefaultSramBase,
    parameter int unsigned PERIPH_AW   = DefaultPeriphAw,
    parameter logic [31:0] PERIPH_BASE = DefaultPeriphBase,
    parameter int unsigned TIMEOUT     = DefaultTimeout
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               data_req_i,
    output logic               data_gnt_o,
    output logic               data_rvalid_o,
    output logic               data_err_o,
    input  logic [31:0]        data_addr_i,
    input  logic               data_we_i,
    input  logic [3:0]         data_be_i,
    input  logic [31:0]        data_wdata_i,
    output logic [31:0]        data_rdata_o,

    output logic               mem_en_o,
    output logic               mem_we_o,
    output logic [3:0]         mem_be_o,
    output logic [SRAM_AW-1:0] mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    input  logic [31:0]        mem_rdata_i,

    output logic               periph_req_o,
    output logic               periph_we_o,
    output logic [3:0]         periph_be_o,
    output logic [31:0]        periph_addr_o,
    output logic [31:0]        periph_wdata_o,
    input  logic               periph_ack_i,
    input  logic [31:0]        periph_rdata_i
);

    localparam logic [TimeoutCntW-1:0] TimeoutCnt = TimeoutCntW'(TIMEOUT);
    localparam logic [TimeoutCntW-1:0] CntMax     = '1;

    bridge_state_e          state_q;
    region_e                region;
    logic                   gnt;
    logic                   resp_we_q;
    logic [31:0]            rdata_q;
    logic [TimeoutCntW-1:0] cnt_q;

    flexbex_bus_addr_decode #(
        .SRAM_AW     (SRAM_AW),
        .SRAM_BASE   (SRAM_BASE),
        .PERIPH_AW   (PERIPH_AW),
        .PERIPH_BASE (PERIPH_BASE)
    ) u_addr_decode (
        .addr   (data_addr_i),
        .region (region)
    );

    // Accept whenever no peripheral access is pending.
    assign gnt        = data_req_i & (state_q != StPeriphWait);
    assign data_gnt_o = gnt;

    // SRAM is driven straight from the request in the grant cycle; enable is
    // masked while reset is asserted.
    assign mem_en_o    = gnt & (region == REGION_SRAM) & rst_n;
    assign mem_we_o    = data_we_i;
    assign mem_be_o    = data_be_i;
    assign mem_addr_o  = data_addr_i[SRAM_AW+1:2];
    assign mem_wdata_o = data_wdata_i;

    assign data_rvalid_o = is_resp_state(state_q);
    assign data_err_o    = (state_q == StErrResp);

    // Load data mux; store and error responses return zero.
    always_comb begin
        data_rdata_o = 32'h0;
        if (!resp_we_q) begin
            if (state_q == StSramResp) begin
                data_rdata_o = mem_rdata_i;
            end else if (state_q == StPeriphResp) begin
                data_rdata_o = rdata_q;
            end
        end
    end

    // Bridge FSM with registered peripheral request, payload, capture and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            resp_we_q      <= 1'b0;
            rdata_q        <= 32'h0;
            cnt_q          <= '0;
            periph_req_o   <= 1'b0;
            periph_we_o    <= 1'b0;
            periph_be_o    <= 4'h0;
            periph_addr_o  <= 32'h0;
            periph_wdata_o <= 32'h0;
        end else begin
            if (state_q == StPeriphWait) begin
                // Ack is checked first so it wins over a timeout in the same cycle.
                if (periph_ack_i) begin
                    rdata_q      <= periph_rdata_i;
                    periph_req_o <= 1'b0;
                    state_q      <= StPeriphResp;
                end else if (cnt_q == TimeoutCnt) begin
                    periph_req_o <= 1'b0;
                    state_q      <= StErrResp;
                end else if (cnt_q != CntMax) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (gnt) begin
                resp_we_q <= data_we_i;
                unique case (region)
                    REGION_SRAM: begin
                        state_q <= StSramResp;
                    end
                    REGION_PERIPH: begin
                        periph_req_o   <= 1'b1;
                        periph_we_o    <= data_we_i;
                        periph_be_o    <= data_be_i;
                        periph_addr_o  <= {data_addr_i[31:2], 2'b00};
                        periph_wdata_o <= data_wdata_i;
                        cnt_q          <= '0;
                        state_q        <= StPeriphWait;
                    end
                    default: begin
                        state_q <= StErrResp;
                    end
                endcase
            end else begin
                state_q <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_flexbex_data_bus_bridge.sv
// Self-checking bench for flexbex_data_bus_bridge: directed vector table, hand
// sequences for back-to-back, wait-state and reset corners, then random traffic
// against a transaction-level model.
module tb_flexbex_data_bus_bridge;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        periph_req_o;
    logic        periph_we_o;
    logic [3:0]  periph_be_o;
    logic [31:0] periph_addr_o;
    logic [31:0] periph_wdata_o;
    logic        periph_ack_i;
    logic [31:0] periph_rdata_i;

    flexbex_data_bus_bridge #(
        .SRAM_AW     (12),
        .SRAM_BASE   (32'h0000_0000),
        .PERIPH_AW   (16),
        .PERIPH_BASE (32'h1000_0000),
        .TIMEOUT     (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_err_o     (data_err_o),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .periph_req_o   (periph_req_o),
        .periph_we_o    (periph_we_o),
        .periph_be_o    (periph_be_o),
        .periph_addr_o  (periph_addr_o),
        .periph_wdata_o (periph_wdata_o),
        .periph_ack_i   (periph_ack_i),
        .periph_rdata_i (periph_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- environment: SRAM and peripheral ----------------
    logic [31:0] sram [4096];
    logic [31:0] preg [16];
    int          ack_delay = -1;
    int          wcnt = 0;
    logic        seen_valid;
    logic [31:0] seen_addr;
    logic        seen_we;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Synchronous single-port SRAM, read-before-write.
    always @(posedge clk) begin
        if (mem_en_o) begin
            mem_rdata_i <= sram[mem_addr_o];
            if (mem_we_o) sram[mem_addr_o] = merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
        end
    end

    // Peripheral: acks ack_delay cycles after its request rises (never if negative).
    always @(negedge clk) begin
        if (!rst_n || !periph_req_o) begin
            periph_ack_i   = 1'b0;
            periph_rdata_i = 32'hBAAD_0000;
            wcnt           = 0;
        end else begin
            if (ack_delay >= 0 && wcnt == ack_delay) begin
                periph_ack_i   = 1'b1;
                periph_rdata_i = preg[periph_addr_o[5:2]];
                seen_valid     = 1'b1;
                seen_addr      = periph_addr_o;
                seen_we        = periph_we_o;
                seen_be        = periph_be_o;
                seen_wdata     = periph_wdata_o;
                if (periph_we_o)
                    preg[periph_addr_o[5:2]] = merge(preg[periph_addr_o[5:2]], periph_wdata_o,
                                                     periph_be_o);
            end else begin
                periph_ack_i   = 1'b0;
                periph_rdata_i = 32'hBAAD_0000;
            end
            wcnt++;
        end
    end

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] ref_sram [4096];
    logic [31:0] ref_preg [16];

    // 0 = SRAM, 1 = peripheral, 2 = unmapped.
    function automatic int region_of(logic [31:0] a);
        if (a < 32'h0000_4000) return 0;
        if (a >= 32'h1000_0000 && a < 32'h1001_0000) return 1;
        return 2;
    endfunction

    task automatic model_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                             input logic [31:0] wdata, input int dly,
                             output logic err, output logic [31:0] rdata, output int lat,
                             output logic is_sram, output logic acked);
        int rg;
        rg = region_of(addr);
        is_sram = (rg == 0);
        acked = 1'b0;
        err = 1'b0;
        rdata = 32'h0;
        lat = 1;
        if (rg == 0) begin
            if (we) ref_sram[addr[13:2]] = merge(ref_sram[addr[13:2]], wdata, be);
            else rdata = ref_sram[addr[13:2]];
        end else if (rg == 1) begin
            if (dly >= 0 && dly <= int'(TMO)) begin
                acked = 1'b1;
                lat = dly + 2;
                if (we) ref_preg[addr[5:2]] = merge(ref_preg[addr[5:2]], wdata, be);
                else rdata = ref_preg[addr[5:2]];
            end else begin
                err = 1'b1;
                lat = int'(TMO) + 2;
            end
        end else begin
            err = 1'b1;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One isolated transaction: request, grant, response, then one idle cycle.
    task automatic do_txn(input string name, input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata, input int dly,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                          input logic exp_sram, input logic exp_ack);
        int lat;
        int k;
        @(negedge clk);
        ack_delay    = dly;
        seen_valid   = 1'b0;
        data_req_i   = 1'b1;
        data_addr_i  = addr;
        data_we_i    = we;
        data_be_i    = be;
        data_wdata_i = wdata;
        #1;
        k = 0;
        while (!data_gnt_o && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({name, " gnt"}, 32'(data_gnt_o), 32'h1);
        if (!data_gnt_o) begin
            data_req_i = 1'b0;
            return;
        end
        chk({name, " mem_en"}, 32'(mem_en_o), 32'(exp_sram));
        if (exp_sram) begin
            chk({name, " mem_addr"}, 32'(mem_addr_o), 32'(addr[13:2]));
            chk({name, " mem_we"}, 32'(mem_we_o), 32'(we));
            if (we) chk({name, " mem_be"}, 32'(mem_be_o), 32'(be));
        end
        @(negedge clk);
        data_req_i = 1'b0;
        #1;
        lat = 1;
        while (!data_rvalid_o && lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk({name, " rvalid"}, 32'(data_rvalid_o), 32'h1);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " err"}, 32'(data_err_o), 32'(exp_err));
        chk({name, " rdata"}, data_rdata_o, exp_rdata);
        if (exp_ack) begin
            chk({name, " periph_seen"}, 32'(seen_valid), 32'h1);
            chk({name, " periph_addr"}, seen_addr, {addr[31:2], 2'b00});
            chk({name, " periph_be"}, 32'(seen_be), 32'(be));
            chk({name, " periph_we"}, 32'(seen_we), 32'(we));
            if (we) chk({name, " periph_wdata"}, seen_wdata, wdata);
        end
        @(negedge clk);
        #1;
        chk({name, " single_rvalid"}, 32'(data_rvalid_o), 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          dly;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t tbl [15];

    initial begin
        automatic logic        m_err;
        automatic logic [31:0] m_rdata;
        automatic int          m_lat;
        automatic logic        m_sram;
        automatic logic        m_ack;
        automatic int          cnt;

        tbl[0]  = '{32'h0000_0010, 1'b0, 4'hF, 32'h0, -1, 1'b0, 32'hDEAD_BEEF, 1};
        tbl[1]  = '{32'h0000_0020, 1'b1, 4'b0110, 32'h1122_3344, -1, 1'b0, 32'h0, 1};
        tbl[2]  = '{32'h0000_0020, 1'b0, 4'hF, 32'h0, -1, 1'b0, 32'h0022_3300, 1};
        tbl[3]  = '{32'h1000_0008, 1'b1, 4'b0011, 32'hCAFE_F00D, 3, 1'b0, 32'h0, 5};
        tbl[4]  = '{32'h1000_0008, 1'b0, 4'hF, 32'h0, 1, 1'b0, 32'h0000_F00D, 3};
        tbl[5]  = '{32'h1000_0004, 1'b0, 4'hF, 32'h0, -1, 1'b1, 32'h0, 6};
        tbl[6]  = '{32'h8000_0000, 1'b0, 4'hF, 32'h0, -1, 1'b1, 32'h0, 1};
        tbl[7]  = '{32'h0000_4000, 1'b1, 4'hF, 32'hFFFF_FFFF, -1, 1'b1, 32'h0, 1};
        tbl[8]  = '{32'h1000_FFFC, 1'b1, 4'hF, 32'h1234_5678, 4, 1'b0, 32'h0, 6};
        tbl[9]  = '{32'h1000_003C, 1'b0, 4'hF, 32'h0, 4, 1'b0, 32'h1234_5678, 6};
        tbl[10] = '{32'h1000_0008, 1'b0, 4'hF, 32'h0, 5, 1'b1, 32'h0, 6};
        tbl[11] = '{32'h0000_3FFC, 1'b1, 4'b1000, 32'hAB00_0000, -1, 1'b0, 32'h0, 1};
        tbl[12] = '{32'h0000_3FFF, 1'b0, 4'b1000, 32'h0, -1, 1'b0, 32'hAB00_0000, 1};
        tbl[13] = '{32'h0FFF_FFFC, 1'b0, 4'hF, 32'h0, -1, 1'b1, 32'h0, 1};
        tbl[14] = '{32'h1001_0000, 1'b0, 4'hF, 32'h0, -1, 1'b1, 32'h0, 1};

        for (int i = 0; i < 4096; i++) begin
            sram[i]     = 32'h0;
            ref_sram[i] = 32'h0;
        end
        for (int i = 0; i < 16; i++) begin
            preg[i]     = 32'h0;
            ref_preg[i] = 32'h0;
        end
        sram[4] = 32'hDEAD_BEEF;  ref_sram[4] = 32'hDEAD_BEEF;
        sram[5] = 32'h0BAD_F00D;  ref_sram[5] = 32'h0BAD_F00D;

        // Reset with a pending request: no SRAM enable, no response, outputs clear.
        rst_n        = 1'b0;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h0000_0010;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset mem_en", 32'(mem_en_o), 32'h0);
        chk("reset rvalid", 32'(data_rvalid_o), 32'h0);
        chk("reset err", 32'(data_err_o), 32'h0);
        chk("reset periph_req", 32'(periph_req_o), 32'h0);
        chk("reset periph_addr", periph_addr_o, 32'h0);
        data_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            model_txn(tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].wdata, tbl[i].dly,
                      m_err, m_rdata, m_lat, m_sram, m_ack);
            do_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].wdata,
                   tbl[i].dly, tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_lat, m_sram, m_ack);
        end

        // Back-to-back misaligned load halves: grants in T and T+1, no bubble.
        @(negedge clk);
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_0012;
        data_we_i   = 1'b0;
        data_be_i   = 4'b1100;
        #1;
        chk("b2b gnt0", 32'(data_gnt_o), 32'h1);
        chk("b2b mem_addr0", 32'(mem_addr_o), 32'h4);
        chk("b2b rvalid_T", 32'(data_rvalid_o), 32'h0);
        @(negedge clk);
        data_addr_i = 32'h0000_0014;
        data_be_i   = 4'b0011;
        #1;
        chk("b2b gnt1", 32'(data_gnt_o), 32'h1);
        chk("b2b mem_en1", 32'(mem_en_o), 32'h1);
        chk("b2b mem_addr1", 32'(mem_addr_o), 32'h5);
        chk("b2b rvalid0", 32'(data_rvalid_o), 32'h1);
        chk("b2b rdata0", data_rdata_o, 32'hDEAD_BEEF);
        @(negedge clk);
        data_req_i = 1'b0;
        #1;
        chk("b2b rvalid1", 32'(data_rvalid_o), 32'h1);
        chk("b2b rdata1", data_rdata_o, 32'h0BAD_F00D);
        @(negedge clk);
        #1;
        chk("b2b idle", 32'(data_rvalid_o), 32'h0);

        // Peripheral load with a waiting SRAM request: no grant until the response cycle.
        @(negedge clk);
        ack_delay   = 2;
        data_req_i  = 1'b1;
        data_addr_i = 32'h1000_0008;
        data_we_i   = 1'b0;
        data_be_i   = 4'hF;
        #1;
        chk("wait gnt", 32'(data_gnt_o), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) data_addr_i = 32'h0000_0010;
            #1;
            chk($sformatf("wait nognt%0d", k), 32'(data_gnt_o), 32'h0);
            chk($sformatf("wait req%0d", k), 32'(periph_req_o), 32'h1);
            chk($sformatf("wait addr%0d", k), periph_addr_o, 32'h1000_0008);
        end
        @(negedge clk);
        #1;
        chk("wait resp rvalid", 32'(data_rvalid_o), 32'h1);
        chk("wait resp err", 32'(data_err_o), 32'h0);
        chk("wait resp rdata", data_rdata_o, ref_preg[2]);
        chk("wait resp gnt", 32'(data_gnt_o), 32'h1);
        chk("wait resp mem_en", 32'(mem_en_o), 32'h1);
        @(negedge clk);
        data_req_i = 1'b0;
        #1;
        chk("wait next rvalid", 32'(data_rvalid_o), 32'h1);
        chk("wait next rdata", data_rdata_o, 32'hDEAD_BEEF);

        // Reset during a peripheral wait abandons the access.
        @(negedge clk);
        ack_delay   = -1;
        data_req_i  = 1'b1;
        data_addr_i = 32'h1000_0010;
        #1;
        chk("rst gnt", 32'(data_gnt_o), 32'h1);
        @(negedge clk);
        data_req_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rst req_before", 32'(periph_req_o), 32'h1);
        @(negedge clk);
        rst_n       = 1'b0;
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_0010;
        #1;
        chk("rst periph_req", 32'(periph_req_o), 32'h0);
        chk("rst rvalid", 32'(data_rvalid_o), 32'h0);
        chk("rst mem_en", 32'(mem_en_o), 32'h0);
        @(negedge clk);
        data_req_i = 1'b0;
        rst_n      = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (data_rvalid_o || periph_req_o) cnt++;
        end
        chk("rst quiet", 32'(cnt), 32'h0);
        model_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0, -1, m_err, m_rdata, m_lat, m_sram, m_ack);
        do_txn("post_rst", 32'h0000_0010, 1'b0, 4'hF, 32'h0, -1, 1'b0, 32'hDEAD_BEEF, 1,
               1'b1, 1'b0);

        // Random traffic against the transaction model.
        for (int i = 0; i < 120; i++) begin
            automatic int          sel = $urandom_range(0, 9);
            automatic logic [31:0] a;
            automatic logic        we = 1'($urandom_range(0, 1));
            automatic logic [3:0]  be = 4'($urandom_range(1, 15));
            automatic logic [31:0] wd = $urandom;
            automatic int          dly = $urandom_range(1, 6);
            if (sel < 5) a = 32'($urandom_range(0, 15)) << 2;
            else if (sel < 8) a = 32'h1000_0000 | (32'($urandom_range(0, 16383)) << 2);
            else a = 32'h2000_0000 + (32'($urandom_range(0, 255)) << 2);
            a[1:0] = 2'($urandom_range(0, 3));
            model_txn(a, we, be, wd, dly, m_err, m_rdata, m_lat, m_sram, m_ack);
            do_txn($sformatf("rnd%0d", i), a, we, be, wd, dly, m_err, m_rdata, m_lat,
                   m_sram, m_ack);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
